// File: rtl/key_scan_scheduler.sv
// key_scan_scheduler: one shared prescaler and a scan FSM debounce N_KEYS inputs and queue press/release events.
// Define KEY_REPEAT_EN to add per-key hold counters that emit auto-repeat press events.
module key_scan_scheduler #(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_i,
    output logic [N_KEYS-1:0] level_o,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [KW-1:0]     evt_key_o,
    output logic              evt_press_o,
    output logic              overflow_o,
    input  logic              clear_ovf_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [N_KEYS-1:0] sync_q, ks_q;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [CW-1:0]     pre_q, pre_d;
    logic [KW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     cnt_q [N_KEYS];
    logic [SW-1:0]     cnt_d [N_KEYS];
    logic [KW:0]       mem_q [FIFO_DEPTH];
    logic [KW:0]       mem_d [FIFO_DEPTH];
    logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
    logic              ovf_q, ovf_d;
    logic              tick, push, push_press, empty, full, pop, accept, drop;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(RMAX + 1);
    logic [HW-1:0]     hold_q [N_KEYS];
    logic [HW-1:0]     hold_d [N_KEYS];
    logic [N_KEYS-1:0] rep_q, rep_d;
`else
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_unused
    end
`endif

    assign tick = pre_q == CW'(TICK_DIV - 1);
    assign pre_d = tick ? '0 : pre_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_press = 1'b0;
`ifdef KEY_REPEAT_EN
        hold_d     = hold_q;
        rep_d      = rep_q;
`endif
        if (state_q == IDLE) begin
            if (tick) begin
                state_d = SCAN;
                idx_d   = '0;
            end
        end else begin
            idx_d = idx_q + KW'(1);
            if (idx_q == KW'(N_KEYS - 1)) begin
                state_d = IDLE;
                idx_d   = '0;
            end
            for (int k = 0; k < N_KEYS; k++) begin
                if (idx_q == KW'(k)) begin
                    if (ks_q[k] == level_q[k]) begin
                        cnt_d[k] = '0;
                    end else if (cnt_q[k] == SW'(STABLE_TICKS - 1)) begin
                        level_d[k] = ~level_q[k];
                        cnt_d[k]   = '0;
                        push       = 1'b1;
                        push_press = ~level_q[k];
                    end else begin
                        cnt_d[k] = cnt_q[k] + SW'(1);
                    end
`ifdef KEY_REPEAT_EN
                    // First phase waits REPEAT_DELAY ticks, later phases REPEAT_RATE ticks.
                    if (level_d[k] != level_q[k] || !level_q[k]) begin
                        hold_d[k] = '0;
                        rep_d[k]  = 1'b0;
                    end else if (hold_q[k] + HW'(1) == (rep_q[k] ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY))) begin
                        hold_d[k]  = '0;
                        rep_d[k]   = 1'b1;
                        push       = 1'b1;
                        push_press = 1'b1;
                    end else begin
                        hold_d[k] = hold_q[k] + HW'(1);
                    end
`endif
                end
            end
        end
    end

    assign empty  = wr_q == rd_q;
    assign full   = (wr_q[PW-1:0] == rd_q[PW-1:0]) && (wr_q[PW] != rd_q[PW]);
    assign pop    = !empty && evt_ready_i;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        mem_d = mem_q;
        wr_d  = accept ? wr_q + (PW+1)'(1) : wr_q;
        rd_d  = pop ? rd_q + (PW+1)'(1) : rd_q;
        ovf_d = drop | (ovf_q & ~clear_ovf_i);
        if (accept) mem_d[wr_q[PW-1:0]] = {idx_q, push_press};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            ks_q    <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            pre_q   <= '0;
            level_q <= '0;
            cnt_q   <= '{default: '0};
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= keys_i;
            ks_q    <= sync_q;
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '{default: '0};
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    assign level_o                  = level_q;
    assign evt_valid_o              = !empty;
    assign {evt_key_o, evt_press_o} = mem_q[rd_q[PW-1:0]];
    assign overflow_o               = ovf_q;
endmodule

// File: tb/tb_key_scan_scheduler.sv
// tb_key_scan_scheduler: directed scenarios plus random keys/ready/clear, checked every cycle against a tick-level model.
module tb_key_scan_scheduler;
    localparam int N = 4, D = 8, S = 3, F = 4, RD = 4, RR = 2;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic [3:0] keys_i = '0;
    logic       evt_ready_i = 1'b0, clear_ovf_i = 1'b0;
    logic [3:0] level_o;
    logic       evt_valid_o, evt_press_o, overflow_o;
    logic [1:0] evt_key_o;

    key_scan_scheduler #(
        .N_KEYS(N), .TICK_DIV(D), .STABLE_TICKS(S), .FIFO_DEPTH(F),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_i(keys_i), .level_o(level_o),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_key_o(evt_key_o),
        .evt_press_o(evt_press_o), .overflow_o(overflow_o), .clear_ovf_i(clear_ovf_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: edges counted from reset release; key k is serviced at edges n>D with (n-1)%D==k,
    // using the raw input seen two edges earlier. Events are {key, press}.
    int         n;
    logic [3:0] kd1, kd2, m_lvl;
    int         m_cnt [N];
    int         m_hold [N];
    logic [2:0] m_q [$];
    logic       m_ovf;
    logic [2:0] log_q [$];

    task automatic model_reset();
        n = 0; kd1 = '0; kd2 = '0; m_lvl = '0; m_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_hold[i] = 0;
        end
        m_q.delete();
    endtask

    task automatic model_edge();
        logic [3:0] samp;
        logic [2:0] ev;
        logic       pop_now, push, drop;
        int         k;
`ifdef KEY_REPEAT_EN
        logic       old;
`endif
        if (!rst_n) return;
        n++;
        pop_now = m_q.size() > 0 && evt_ready_i;
        push = 1'b0;
        ev = '0;
        samp = kd2; kd2 = kd1; kd1 = keys_i;
        if (n > D && (n - 1) % D < N) begin
            k = (n - 1) % D;
`ifdef KEY_REPEAT_EN
            old = m_lvl[k];
`endif
            if (samp[k] == m_lvl[k]) m_cnt[k] = 0;
            else if (m_cnt[k] == S - 1) begin
                m_lvl[k] = ~m_lvl[k];
                m_cnt[k] = 0;
                push = 1'b1;
                ev = {2'(k), m_lvl[k]};
            end else m_cnt[k]++;
`ifdef KEY_REPEAT_EN
            if (m_lvl[k] != old || !m_lvl[k]) m_hold[k] = 0;
            else begin
                m_hold[k]++;
                if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RR == 0)) begin
                    push = 1'b1;
                    ev = {2'(k), 1'b1};
                end
            end
`endif
        end
        drop = push && m_q.size() == F && !pop_now;
        if (pop_now) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(ev);
        m_ovf = drop ? 1'b1 : clear_ovf_i ? 1'b0 : m_ovf;
    endtask

    task automatic compare();
        logic [2:0] h;
        check("level", level_o, m_lvl);
        check("valid", evt_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) begin
            h = m_q[0];
            check("head_key", evt_key_o, h[2:1]);
            check("head_press", evt_press_o, h[0]);
        end
        check("overflow", overflow_o, m_ovf);
    endtask

    task automatic step();
        if (rst_n && evt_valid_o && evt_ready_i) log_q.push_back({evt_key_o, evt_press_o});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int c);
        repeat (c) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_level", level_o, 0);
        check("rst_valid", evt_valid_o, 0);
        check("rst_key", evt_key_o, 0);
        check("rst_press", evt_press_o, 0);
        check("rst_ovf", overflow_o, 0);
        run(3);
        rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic wait_valid(input int max, input string tag);
        int i = 0;
        while (!evt_valid_o && i < max) begin
            step();
            i++;
        end
        check(tag, evt_valid_o, 1);
    endtask

    function automatic logic [2:0] ev_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 3'bxxx;
    endfunction

    function automatic int count_ev(input logic [2:0] e);
        int c = 0;
        foreach (log_q[i]) if (log_q[i] == e) c++;
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pulsed;
        int len;
        #2;
        // 1: reset with all keys held, then four presses in key order
        keys_i = 4'hF;
        do_reset();
        run(32);
        check("s1_level", level_o, 4'hF);
        evt_ready_i = 1'b1;
        run(6);
        check("s1_ev0", ev_at(0), 3'b001);
        check("s1_ev1", ev_at(1), 3'b011);
        check("s1_ev2", ev_at(2), 3'b101);
        check("s1_ev3", ev_at(3), 3'b111);
        // 2: single key press and release
        keys_i = 4'h0;
        run(40);
        log_q.delete();
        keys_i[2] = 1'b1;
        run(32);
        check("s2_level", level_o[2], 1);
        run(8);
        keys_i[2] = 1'b0;
        run(40);
        check("s2_first", ev_at(0), 3'b101);
        check("s2_last", ev_at(log_q.size() - 1), 3'b100);
`ifndef KEY_REPEAT_EN
        check("s2_count", log_q.size(), 2);
`endif
        // 3: bounce shorter than the stable window stays invisible
        log_q.delete();
        pulsed = 1'b0;
        for (int t = 0; t < 20; t++) begin
            keys_i[1] = ~keys_i[1];
            for (int c = 0; c < 10; c++) begin
                step();
                if (level_o[1]) pulsed = 1'b1;
            end
        end
        keys_i[1] = 1'b1;
        run(40);
        check("s3_no_pulse", pulsed, 0);
        check("s3_ev", ev_at(0), 3'b011);
`ifndef KEY_REPEAT_EN
        check("s3_count", log_q.size(), 1);
`endif
        // 4: overflow with a stalled consumer, then drain and clear
        keys_i = 4'h0;
        run(40);
        evt_ready_i = 1'b0;
        log_q.delete();
        keys_i = 4'hF;
        run(40);
        keys_i[0] = 1'b0;
        run(40);
        check("s4_valid", evt_valid_o, 1);
        check("s4_ovf", overflow_o, 1);
        evt_ready_i = 1'b1;
        run(4);
        check("s4_drain_n", log_q.size() >= 4, 1);
        check("s4_ev0", ev_at(0), 3'b001);
        check("s4_ev1", ev_at(1), 3'b011);
        check("s4_ev2", ev_at(2), 3'b101);
        check("s4_ev3", ev_at(3), 3'b111);
        clear_ovf_i = 1'b1;
        step();
        clear_ovf_i = 1'b0;
        check("s4_clear", overflow_o, 0);
        // 5: simultaneous presses in key order, then reset mid-scan with queued events
        keys_i = 4'h0;
        run(40);
        log_q.delete();
        evt_ready_i = 1'b0;
        keys_i = 4'b1001;
        wait_valid(40, "s5_wait");
        run(4);
        evt_ready_i = 1'b1;
        run(3);
        check("s5_ev0", ev_at(0), 3'b001);
        check("s5_ev1", ev_at(1), 3'b111);
        evt_ready_i = 1'b0;
        keys_i = 4'h0;
        wait_valid(40, "s5_wait_rel");
        for (int i = 0; i < D && n % D != 2; i++) step();
        check("s5_midscan", n % D, 2);
        do_reset();
        // 6: held key, auto-repeat only when enabled
        evt_ready_i = 1'b1;
        keys_i[0] = 1'b1;
        run(120);
        keys_i[0] = 1'b0;
        run(40);
`ifdef KEY_REPEAT_EN
        check("s6_repeats", count_ev(3'b001) >= 3, 1);
`else
        check("s6_single", count_ev(3'b001), 1);
`endif
        check("s6_release", ev_at(log_q.size() - 1), 3'b000);
        // random keys, back-pressure and overflow clears
        for (int r = 0; r < 30; r++) begin
            keys_i = 4'($urandom);
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                evt_ready_i = $urandom_range(0, 2) == 0;
                clear_ovf_i = $urandom_range(0, 15) == 0;
                step();
            end
        end
        clear_ovf_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
